// File: rtl/debouncer_multi.sv
// Multi-channel key debouncer: per-channel synchroniser, glitch filter, level plus press/release strobes.
// Define DEBOUNCER_REPEAT_EN to add an auto-repeat generator that re-fires the press strobe while a key is held.
module debouncer_multi #(
  parameter int CHANNELS             = 4,
  parameter int CLK_FREQ_MHZ         = 100,
  parameter int GLITCH_TIME_NS       = 100,
  parameter int SYNC_STAGES          = 2,
  parameter int REPEAT_DELAY_CYCLES  = 50,
  parameter int REPEAT_PERIOD_CYCLES = 20
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [CHANNELS-1:0] key_i,
  output logic [CHANNELS-1:0] key_state_o,
  output logic [CHANNELS-1:0] key_pressed_stb_o,
  output logic [CHANNELS-1:0] key_released_stb_o
);

  localparam int GLITCH_RAW    = (GLITCH_TIME_NS * CLK_FREQ_MHZ) / 1000;
  localparam int GLITCH_CYCLES = (GLITCH_RAW < 1) ? 1 : GLITCH_RAW;
  localparam int CNT_W         = $clog2(GLITCH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GLITCH_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (CHANNELS < 1) begin : g_chk_channels
    $error("debouncer_multi: CHANNELS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("debouncer_multi: SYNC_STAGES must be >= 2");
  end
  if (REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_chk_repeat
    $error("debouncer_multi: repeat delay and period must be >= 1");
  end

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [SYNC_STAGES-1:0] sync_d [CHANNELS];
  logic [CNT_W-1:0]       cnt_q  [CHANNELS];
  logic [CNT_W-1:0]       cnt_d  [CHANNELS];
  logic [CHANNELS-1:0]    state_q, state_d;
  logic [CHANNELS-1:0]    press_q, press_d;
  logic [CHANNELS-1:0]    rel_q,   rel_d;

`ifdef DEBOUNCER_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY_CYCLES > REPEAT_PERIOD_CYCLES) ?
                           REPEAT_DELAY_CYCLES : REPEAT_PERIOD_CYCLES;
  localparam int RCNT_W  = $clog2(RPT_MAX + 1);
  localparam logic [RCNT_W-1:0] RPT_DELAY  = RCNT_W'(REPEAT_DELAY_CYCLES);
  localparam logic [RCNT_W-1:0] RPT_PERIOD = RCNT_W'(REPEAT_PERIOD_CYCLES);

  logic [RCNT_W-1:0]   rcnt_q [CHANNELS];
  logic [RCNT_W-1:0]   rcnt_d [CHANNELS];
  logic [CHANNELS-1:0] rphase_q, rphase_d;
`endif

  always_comb begin
    logic             sync_bit;
    logic             filter_evt;
`ifdef DEBOUNCER_REPEAT_EN
    logic [RCNT_W-1:0] rcnt_inc;
    logic              rpt_fire;
`endif
    sync_bit   = 1'b0;
    filter_evt = 1'b0;
`ifdef DEBOUNCER_REPEAT_EN
    rcnt_inc   = '0;
    rpt_fire   = 1'b0;
    rphase_d   = rphase_q;
`endif
    state_d = state_q;
    press_d = '0;
    rel_d   = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      sync_d[n]  = {sync_q[n][SYNC_STAGES-2:0], key_i[n]};
      sync_bit   = sync_q[n][SYNC_STAGES-1];
      filter_evt = 1'b0;
      cnt_d[n]   = cnt_q[n];

      if (sync_bit == state_q[n]) begin
        cnt_d[n] = '0;
      end else if (cnt_q[n] == CNT_LAST) begin
        cnt_d[n]   = '0;
        state_d[n] = sync_bit;
        press_d[n] = sync_bit;
        rel_d[n]   = ~sync_bit;
        filter_evt = 1'b1;
      end else begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end

`ifdef DEBOUNCER_REPEAT_EN
      // Repeat runs only while the key is settled high; any filter event restarts it.
      rcnt_d[n] = rcnt_q[n];
      rpt_fire  = 1'b0;
      rcnt_inc  = rcnt_q[n] + 1'b1;
      if (!state_q[n] || filter_evt) begin
        rcnt_d[n]   = '0;
        rphase_d[n] = 1'b0;
      end else if (!rphase_q[n]) begin
        if (rcnt_inc == RPT_DELAY) begin
          rcnt_d[n]   = '0;
          rphase_d[n] = 1'b1;
          rpt_fire    = 1'b1;
        end else begin
          rcnt_d[n] = rcnt_inc;
        end
      end else begin
        if (rcnt_inc == RPT_PERIOD) begin
          rcnt_d[n] = '0;
          rpt_fire  = 1'b1;
        end else begin
          rcnt_d[n] = rcnt_inc;
        end
      end
      press_d[n] = press_d[n] | rpt_fire;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < CHANNELS; n++) begin
        sync_q[n] <= '0;
        cnt_q[n]  <= '0;
      end
      state_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        sync_q[n] <= sync_d[n];
        cnt_q[n]  <= cnt_d[n];
      end
      state_q <= state_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

`ifdef DEBOUNCER_REPEAT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int n = 0; n < CHANNELS; n++) begin
        rcnt_q[n] <= '0;
      end
      rphase_q <= '0;
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        rcnt_q[n] <= rcnt_d[n];
      end
      rphase_q <= rphase_d;
    end
  end
`endif

  assign key_state_o        = state_q;
  assign key_pressed_stb_o  = press_q;
  assign key_released_stb_o = rel_q;

endmodule

// File: tb/tb_debouncer_multi.sv
// Bench for debouncer_multi at default parameters: table-driven pulses plus hand-written corner sequences.
// Expected strobe events are queued when stimulus is driven and matched against events seen on the outputs.
module tb_debouncer_multi;

  localparam int CH  = 4;
  localparam int LAT = 12;

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b0;
  logic [CH-1:0] key_i  = '0;
  logic [CH-1:0] key_state_o;
  logic [CH-1:0] key_pressed_stb_o;
  logic [CH-1:0] key_released_stb_o;

  debouncer_multi dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .key_i              (key_i),
    .key_state_o        (key_state_o),
    .key_pressed_stb_o  (key_pressed_stb_o),
    .key_released_stb_o (key_released_stb_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks  = 0;
  int errors  = 0;
  int overlap = 0;
  int exp_q[$];
  int obs_q[$];

  // Event code: edge_index*64 + channel*2 + kind (0 press, 1 release).
  function automatic int ev(int c, int ch, int kind);
    return c * 64 + ch * 2 + kind;
  endfunction

  always @(negedge clk_i) begin
    if (rst_ni) begin
      for (int ch = 0; ch < CH; ch++) begin
        if (key_pressed_stb_o[ch])  obs_q.push_back(ev(cyc, ch, 0));
        if (key_released_stb_o[ch]) obs_q.push_back(ev(cyc, ch, 1));
        if (key_pressed_stb_o[ch] && key_released_stb_o[ch]) overlap++;
      end
    end
  end

  task automatic check(string name, int act, int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic check_events(string name);
    exp_q.sort();
    obs_q.sort();
    check({name, " event count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({name, " event (cyc*64+ch*2+kind)"}, obs_q[i], exp_q[i]);
    exp_q.delete();
    obs_q.delete();
  endtask

  typedef struct {
    string name;
    int    ch;
    int    width;
    bit    accept;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int e;
    int r;

    vecs[0] = '{"clean press ch0 w30", 0, 30, 1'b1};
    vecs[1] = '{"glitch ch1 w9",       1,  9, 1'b0};
    vecs[2] = '{"min pulse ch1 w10",   1, 10, 1'b1};
    vecs[3] = '{"pulse ch2 w15",       2, 15, 1'b1};
    vecs[4] = '{"spike ch3 w1",        3,  1, 1'b0};
    vecs[5] = '{"pulse ch3 w11",       3, 11, 1'b1};

    tick(3);
    check("reset key_state", int'(key_state_o), 0);
    check("reset press_stb", int'(key_pressed_stb_o), 0);
    check("reset release_stb", int'(key_released_stb_o), 0);
    rst_ni = 1'b1;
    tick(5);

    for (int i = 0; i < 6; i++) begin
      key_i[vecs[i].ch] = 1'b1;
      e = cyc;
      if (vecs[i].accept) exp_q.push_back(ev(e + LAT, vecs[i].ch, 0));
      tick(vecs[i].width);
      key_i[vecs[i].ch] = 1'b0;
      if (vecs[i].accept) exp_q.push_back(ev(e + vecs[i].width + LAT, vecs[i].ch, 1));
      tick(30);
      check({vecs[i].name, " final state"}, int'(key_state_o), 0);
      check_events(vecs[i].name);
    end

    // Bounce: 3-cycle toggles never settle, then a final rising edge held.
    for (int i = 0; i < 14; i++) begin
      key_i[2] = ~key_i[2];
      tick(3);
    end
    key_i[2] = 1'b1;
    e = cyc;
    exp_q.push_back(ev(e + LAT, 2, 0));
    tick(20);
    check("bounce held state", int'(key_state_o), 4);
    key_i[2] = 1'b0;
    exp_q.push_back(ev(cyc + LAT, 2, 1));
    tick(30);
    check_events("bounce");

    // Concurrent press/release on ch0 and ch3.
    key_i = 4'b1001;
    e = cyc;
    exp_q.push_back(ev(e + LAT, 0, 0));
    exp_q.push_back(ev(e + LAT, 3, 0));
    tick(25);
    check("concurrent held state", int'(key_state_o), 9);
    key_i = 4'b0000;
    e = cyc;
    exp_q.push_back(ev(e + LAT, 0, 1));
    exp_q.push_back(ev(e + LAT, 3, 1));
    tick(30);
    check_events("concurrent");

    // Reset mid-debounce, with ch0 already settled high.
    key_i[0] = 1'b1;
    exp_q.push_back(ev(cyc + LAT, 0, 0));
    tick(20);
    check("pre-reset state", int'(key_state_o), 1);
    check_events("pre-reset");
    key_i[1] = 1'b1;
    tick(6);
    rst_ni = 1'b0;
    #1;
    check("async reset key_state", int'(key_state_o), 0);
    check("async reset press_stb", int'(key_pressed_stb_o), 0);
    check("async reset release_stb", int'(key_released_stb_o), 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    r = cyc;
    exp_q.push_back(ev(r + LAT, 0, 0));
    exp_q.push_back(ev(r + LAT, 1, 0));
    tick(LAT - 1);
    check("post-reset state before accept", int'(key_state_o), 0);
    tick(1);
    check("post-reset state at accept", int'(key_state_o), 3);
    tick(8);
    key_i = 4'b0000;
    e = cyc;
    exp_q.push_back(ev(e + LAT, 0, 1));
    exp_q.push_back(ev(e + LAT, 1, 1));
    tick(30);
    check_events("reset re-accept");

`ifdef DEBOUNCER_REPEAT_EN
    key_i[0] = 1'b1;
    e = cyc;
    exp_q.push_back(ev(e + LAT, 0, 0));
    for (int t = e + LAT + 50; t < e + LAT + 200; t += 20)
      exp_q.push_back(ev(t, 0, 0));
    tick(200);
    key_i[0] = 1'b0;
    exp_q.push_back(ev(e + 200 + LAT, 0, 1));
    tick(40);
    check_events("auto-repeat");
`endif

    check("strobe overlap count", overlap, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
